// File: rtl/fetch_stage_pkg.sv
// Shared pipeline constants for the fetch stage: NOP/HALT encodings, opcode
// field bounds and the fetch FSM state encoding.
package fetch_stage_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]  OP_HALT   = 5'b00000;
  localparam int          OPC_HI    = 15;
  localparam int          OPC_LO    = 11;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  function automatic logic is_halt(input logic [15:0] instr);
    return (instr[OPC_HI:OPC_LO] == OP_HALT);
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: async reset to RESET_PC, load-enable, and a
// next-value select between PC+2 and an externally supplied target.
module pc_reg #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic             sel_target,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc
);

  localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-2){1'b0}}, 2'b10};

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_next_s;

  // Next-PC select; the increment wraps modulo 2^WIDTH.
  always_comb begin
    pc_next_s = pc_r + PC_STEP;
    if (sel_target) begin
      pc_next_s = target;
    end else begin
      pc_next_s = pc_r + PC_STEP;
    end
  end

  // PC state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (load_en) begin
      pc_r <= pc_next_s;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, RUN/HALTED FSM, stall and
// redirect handling. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             insert_nop,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_data,
  output logic [WIDTH-1:0] IF_ID_instr,
  output logic [WIDTH-1:0] IF_ID_pc_plus2,
  output logic             IF_ID_valid,
  output logic             halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
`endif
);

  localparam logic [WIDTH-1:0] PC_STEP    = {{(WIDTH-2){1'b0}}, 2'b10};
  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-1){1'b1}}, 1'b0};

  fetch_state_e     state_r, next_state_s;
  logic [WIDTH-1:0] pc_s;
  logic [WIDTH-1:0] pc_plus2_s;
  logic [WIDTH-1:0] target_s;
  logic             pc_load_s;
  logic             pc_sel_target_s;
  logic             ifid_load_s;
  logic [WIDTH-1:0] ifid_instr_s;
  logic [WIDTH-1:0] ifid_pc2_s;
  logic             ifid_valid_s;
  logic [WIDTH-1:0] ifid_instr_r;
  logic [WIDTH-1:0] ifid_pc2_r;
  logic             ifid_valid_r;

  assign pc_plus2_s = pc_s + PC_STEP;
  assign target_s   = redirect_pc & ALIGN_MASK;

  pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .load_en    (pc_load_s),
    .sel_target (pc_sel_target_s),
    .target     (target_s),
    .pc         (pc_s)
  );

  // Next-state and IF/ID load decision, redirect > stall > halted > run.
  always_comb begin
    next_state_s    = state_r;
    pc_load_s       = 1'b0;
    pc_sel_target_s = 1'b0;
    ifid_load_s     = 1'b0;
    ifid_instr_s    = NOP_INSTR;
    ifid_pc2_s      = ifid_pc2_r;
    ifid_valid_s    = 1'b0;
    if (redirect) begin
      next_state_s    = ST_RUN;
      pc_load_s       = 1'b1;
      pc_sel_target_s = 1'b1;
      ifid_load_s     = 1'b1;
    end else if (insert_nop) begin
      next_state_s = state_r;
    end else begin
      case (state_r)
        ST_HALTED: begin
          ifid_load_s = 1'b1;
        end
        ST_RUN: begin
          ifid_load_s  = 1'b1;
          ifid_instr_s = imem_data;
          ifid_pc2_s   = pc_plus2_s;
          ifid_valid_s = 1'b1;
          // A fetched HALT is still handed to decode, but the PC parks on it.
          if (is_halt(imem_data)) begin
            next_state_s = ST_HALTED;
          end else begin
            pc_load_s = 1'b1;
          end
        end
        default: begin
          next_state_s = ST_RUN;
        end
      endcase
    end
  end

  // FSM state and IF/ID pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_RUN;
      ifid_instr_r <= NOP_INSTR;
      ifid_pc2_r   <= '0;
      ifid_valid_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (ifid_load_s) begin
        ifid_instr_r <= ifid_instr_s;
        ifid_pc2_r   <= ifid_pc2_s;
        ifid_valid_r <= ifid_valid_s;
      end
    end
  end

  assign imem_addr      = pc_s;
  assign IF_ID_instr    = ifid_instr_r;
  assign IF_ID_pc_plus2 = ifid_pc2_r;
  assign IF_ID_valid    = ifid_valid_r;
  assign halted         = (state_r == ST_HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_r;
  logic [15:0] flush_cnt_r;

  // Saturating stall/flush counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
      flush_cnt_r <= 16'h0000;
    end else begin
      if (insert_nop && !redirect && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'h0001;
      end
      if (redirect && (flush_cnt_r != 16'hFFFF)) begin
        flush_cnt_r <= flush_cnt_r + 16'h0001;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; counter checks are compiled
// in only when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        insert_nop;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] IF_ID_instr;
  logic [15:0] IF_ID_pc_plus2;
  logic        IF_ID_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  logic [15:0] mem [0:32767];
  int          pass_cnt;
  int          total_cnt;

  fetch_stage #(
    .WIDTH    (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .insert_nop     (insert_nop),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .IF_ID_instr    (IF_ID_instr),
    .IF_ID_pc_plus2 (IF_ID_pc_plus2),
    .IF_ID_valid    (IF_ID_valid),
    .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  assign imem_data = mem[imem_addr[15:1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    pass_cnt    = 0;
    total_cnt   = 0;
    rst         = 1'b0;
    insert_nop  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    for (int i = 0; i < 32768; i++) mem[i] = 16'h4000 | (16'(i) & 16'h07FF);
    mem[16'h0000 >> 1] = 16'h4001;
    mem[16'h0002 >> 1] = 16'h4202;
    mem[16'h0004 >> 1] = 16'h4404;
    mem[16'h0008 >> 1] = 16'h0000;
    mem[16'h0010 >> 1] = 16'h4810;
    mem[16'hFFFE >> 1] = 16'h4ABC;

    #1 rst = 1'b1;
    #1;
    check_eq("rst_addr",  imem_addr, 16'h0000);
    check_eq("rst_instr", IF_ID_instr, 16'h0800);
    check_eq("rst_pc2",   IF_ID_pc_plus2, 16'h0000);
    check_eq("rst_valid", {15'd0, IF_ID_valid}, 16'h0000);
    check_eq("rst_halt",  {15'd0, halted}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    step();
    check_eq("f1_instr", IF_ID_instr, 16'h4001);
    check_eq("f1_pc2",   IF_ID_pc_plus2, 16'h0002);
    check_eq("f1_valid", {15'd0, IF_ID_valid}, 16'h0001);
    step();
    check_eq("f2_instr", IF_ID_instr, 16'h4202);
    check_eq("f2_pc2",   IF_ID_pc_plus2, 16'h0004);
    check_eq("f2_addr",  imem_addr, 16'h0004);

    insert_nop = 1'b1;
    step();
    check_eq("stall_addr",  imem_addr, 16'h0004);
    check_eq("stall_instr", IF_ID_instr, 16'h4202);
    check_eq("stall_pc2",   IF_ID_pc_plus2, 16'h0004);
    insert_nop = 1'b0;
    step();
    check_eq("post_stall_instr", IF_ID_instr, 16'h4404);
    check_eq("post_stall_addr",  imem_addr, 16'h0006);

    redirect    = 1'b1;
    redirect_pc = 16'h0021;
    step();
    redirect = 1'b0;
    check_eq("redir_addr",  imem_addr, 16'h0020);
    check_eq("redir_instr", IF_ID_instr, 16'h0800);
    check_eq("redir_valid", {15'd0, IF_ID_valid}, 16'h0000);
`ifdef FETCH_PERF_CNT_EN
    check_eq("redir_flush", flush_cnt, 16'h0001);
    check_eq("redir_stall", stall_cnt, 16'h0001);
`endif

    redirect    = 1'b1;
    redirect_pc = 16'h0008;
    step();
    redirect = 1'b0;
    check_eq("to8_addr", imem_addr, 16'h0008);
    step();
    check_eq("halt_instr", IF_ID_instr, 16'h0000);
    check_eq("halt_valid", {15'd0, IF_ID_valid}, 16'h0001);
    check_eq("halt_pc2",   IF_ID_pc_plus2, 16'h000A);
    check_eq("halt_flag",  {15'd0, halted}, 16'h0001);
    check_eq("halt_addr",  imem_addr, 16'h0008);
    step();
    check_eq("parked_instr", IF_ID_instr, 16'h0800);
    check_eq("parked_valid", {15'd0, IF_ID_valid}, 16'h0000);
    check_eq("parked_addr",  imem_addr, 16'h0008);
    check_eq("parked_flag",  {15'd0, halted}, 16'h0001);

    redirect    = 1'b1;
    redirect_pc = 16'h0010;
    step();
    redirect = 1'b0;
    check_eq("resume_flag",  {15'd0, halted}, 16'h0000);
    check_eq("resume_addr",  imem_addr, 16'h0010);
    check_eq("resume_instr", IF_ID_instr, 16'h0800);
    step();
    check_eq("resume_fetch", IF_ID_instr, 16'h4810);
    check_eq("resume_pc2",   IF_ID_pc_plus2, 16'h0012);

    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    check_eq("wrap_pre_addr", imem_addr, 16'hFFFE);
    step();
    check_eq("wrap_addr",  imem_addr, 16'h0000);
    check_eq("wrap_pc2",   IF_ID_pc_plus2, 16'h0000);
    check_eq("wrap_instr", IF_ID_instr, 16'h4ABC);

    redirect    = 1'b1;
    insert_nop  = 1'b1;
    redirect_pc = 16'h0030;
    step();
    redirect   = 1'b0;
    insert_nop = 1'b0;
    check_eq("both_addr",  imem_addr, 16'h0030);
    check_eq("both_instr", IF_ID_instr, 16'h0800);
`ifdef FETCH_PERF_CNT_EN
    check_eq("both_stall", stall_cnt, 16'h0001);
    check_eq("both_flush", flush_cnt, 16'h0005);
`endif

    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    step();
    redirect   = 1'b0;
    insert_nop = 1'b1;
    step();
    check_eq("pre_rst_addr", imem_addr, 16'h0040);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_addr",  imem_addr, 16'h0000);
    check_eq("arst_instr", IF_ID_instr, 16'h0800);
    check_eq("arst_valid", {15'd0, IF_ID_valid}, 16'h0000);
    check_eq("arst_pc2",   IF_ID_pc_plus2, 16'h0000);
`ifdef FETCH_PERF_CNT_EN
    check_eq("arst_stall", stall_cnt, 16'h0000);
    check_eq("arst_flush", flush_cnt, 16'h0000);
`endif
    @(negedge clk);
    rst        = 1'b0;
    insert_nop = 1'b0;
    step();
    check_eq("refetch_instr", IF_ID_instr, 16'h4001);
    check_eq("refetch_addr",  imem_addr, 16'h0002);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
